// File: rtl/mac_learn_table.sv
// -----------------------------------------------------------------------------
// mac_learn_table
//   Direct-mapped MAC learning / forwarding table for the switch datapath.
//   Learns source-key -> ingress port, answers destination-key lookups with
//   an egress port (hit) or a flood indication (miss), and ages entries out
//   with a background sweeper driven by a free-running tick counter.
//
// Parameters
//   pKEY_W        MAC key width; the table holds 2**pKEY_W slots
//   pPORT_W       port number width
//   pAGE_MAX      age reload value on learn, in ticks
//   pTICK_CYCLES  clock cycles per aging tick
//
// Ports
//   iclk            clock
//   irst            synchronous active-high reset
//   i_flush         1-cycle pulse: invalidate the whole table
//   i_learn_valid   learn request
//   i_learn_mac     source key to learn
//   i_learn_port    ingress port of the source key
//   i_lookup_valid  lookup request
//   i_lookup_mac    destination key to look up
//   o_lookup_valid  lookup result strobe (1 cycle after request)
//   o_hit           looked-up key has a valid entry
//   o_port_num      egress port on hit, 0 otherwise
//   o_flood         lookup result strobe without a hit
//   o_move          1-cycle pulse: a learn changed the port of a valid entry
//   o_ready         table initialised, learns accepted
//   o_entries       number of valid entries
// -----------------------------------------------------------------------------
module mac_learn_table #(
    parameter int pKEY_W       = 14,
    parameter int pPORT_W      = 4,
    parameter int pAGE_MAX     = 300,
    parameter int pTICK_CYCLES = 32768
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic               i_flush,
    input  logic               i_learn_valid,
    input  logic [pKEY_W-1:0]  i_learn_mac,
    input  logic [pPORT_W-1:0] i_learn_port,
    input  logic               i_lookup_valid,
    input  logic [pKEY_W-1:0]  i_lookup_mac,
    output logic               o_lookup_valid,
    output logic               o_hit,
    output logic [pPORT_W-1:0] o_port_num,
    output logic               o_flood,
    output logic               o_move,
    output logic               o_ready,
    output logic [pKEY_W:0]    o_entries
);

    localparam int SLOTS  = 2 ** pKEY_W;
    localparam int AGE_W  = $clog2(pAGE_MAX + 1);
    localparam int TICK_W = (pTICK_CYCLES > 1) ? $clog2(pTICK_CYCLES) : 1;
    localparam int ENT_W  = pKEY_W + 1;

    localparam logic [pKEY_W-1:0] LAST_SLOT  = {pKEY_W{1'b1}};
    localparam logic [pKEY_W-1:0] PTR_ONE    = pKEY_W'(1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(pTICK_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
    localparam logic [AGE_W-1:0]  AGE_RELOAD = AGE_W'(pAGE_MAX);
    localparam logic [AGE_W-1:0]  AGE_ONE    = AGE_W'(1);
    localparam logic [ENT_W-1:0]  ENT_ONE    = ENT_W'(1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_AGE  = 2'd2
    } state_t;

    // Table storage, split per field. Not reset: the INIT sweep clears it.
    logic               r_valid [SLOTS];
    logic [pPORT_W-1:0] r_port  [SLOTS];
    logic [AGE_W-1:0]   r_age   [SLOTS];

    state_t             r_state;
    logic [pKEY_W-1:0]  r_ptr;
    logic [TICK_W-1:0]  r_tick_cnt;
    logic               r_pending;
    logic               r_ready;
    logic [ENT_W-1:0]   r_entries;
    logic               r_lookup_valid;
    logic               r_hit;
    logic [pPORT_W-1:0] r_port_num;
    logic               r_flood;
    logic               r_move;

    logic               w_tick;
    logic               w_learn_ok;
    logic               w_learn_slot_valid;
    logic [pPORT_W-1:0] w_learn_slot_port;
    logic               w_lk_hit;
    logic               w_sweep_valid;
    logic [pPORT_W-1:0] w_sweep_port;
    logic [AGE_W-1:0]   w_sweep_age;
    logic               w_age_step;
    logic               w_expire;

    logic               w_wr_en;
    logic [pKEY_W-1:0]  w_wr_addr;
    logic               w_wr_valid;
    logic [pPORT_W-1:0] w_wr_port;
    logic [AGE_W-1:0]   w_wr_age;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Learns are only taken once the table is initialised; flush overrides.
    assign w_learn_ok         = r_ready & i_learn_valid & ~i_flush;
    assign w_learn_slot_valid = r_valid[i_learn_mac];
    assign w_learn_slot_port  = r_port[i_learn_mac];

    // Lookups read the table before any same-cycle write lands.
    assign w_lk_hit = i_lookup_valid & r_ready & r_valid[i_lookup_mac];

    assign w_sweep_valid = r_valid[r_ptr];
    assign w_sweep_port  = r_port[r_ptr];
    assign w_sweep_age   = r_age[r_ptr];

    // A learn owns the single write port, so the sweep stalls that cycle.
    assign w_age_step = (r_state == ST_AGE) & ~w_learn_ok & ~i_flush;
    assign w_expire   = w_age_step & w_sweep_valid & (w_sweep_age == AGE_ONE);

    // Single write port: INIT clear, learn, or aging update.
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_addr  = r_ptr;
        w_wr_valid = 1'b0;
        w_wr_port  = '0;
        w_wr_age   = '0;
        if (!irst && !i_flush) begin
            if (r_state == ST_INIT) begin
                w_wr_en = 1'b1;
            end else if (w_learn_ok) begin
                w_wr_en    = 1'b1;
                w_wr_addr  = i_learn_mac;
                w_wr_valid = 1'b1;
                w_wr_port  = i_learn_port;
                w_wr_age   = AGE_RELOAD;
            end else if (w_age_step && w_sweep_valid) begin
                w_wr_en    = 1'b1;
                w_wr_valid = ~w_expire;
                w_wr_port  = w_sweep_port;
                w_wr_age   = w_sweep_age - AGE_ONE;
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (w_wr_en) begin
            r_valid[w_wr_addr] <= w_wr_valid;
            r_port[w_wr_addr]  <= w_wr_port;
            r_age[w_wr_addr]   <= w_wr_age;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state        <= ST_INIT;
            r_ptr          <= '0;
            r_tick_cnt     <= '0;
            r_pending      <= 1'b0;
            r_ready        <= 1'b0;
            r_entries      <= '0;
            r_lookup_valid <= 1'b0;
            r_hit          <= 1'b0;
            r_port_num     <= '0;
            r_flood        <= 1'b0;
            r_move         <= 1'b0;
        end else begin
            // Tick counter free-runs regardless of state or flush.
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_ONE;

            r_lookup_valid <= i_lookup_valid;
            r_hit          <= w_lk_hit;
            r_port_num     <= w_lk_hit ? r_port[i_lookup_mac] : '0;
            r_flood        <= i_lookup_valid & ~w_lk_hit;

            r_move <= w_learn_ok & w_learn_slot_valid &
                      (w_learn_slot_port != i_learn_port);

            if (i_flush) begin
                r_state   <= ST_INIT;
                r_ptr     <= '0;
                r_ready   <= 1'b0;
                r_entries <= '0;
                r_pending <= 1'b0;
            end else begin
                // Learn into an empty slot and expiry never coincide
                // because a learn stalls the sweep.
                if (w_learn_ok && !w_learn_slot_valid) begin
                    r_entries <= r_entries + ENT_ONE;
                end else if (w_expire) begin
                    r_entries <= r_entries - ENT_ONE;
                end

                case (r_state)
                    ST_INIT: begin
                        if (w_tick) begin
                            r_pending <= 1'b1;
                        end
                        r_ptr <= r_ptr + PTR_ONE;
                        if (r_ptr == LAST_SLOT) begin
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
                        end
                    end
                    ST_IDLE: begin
                        if (w_tick || r_pending) begin
                            r_state   <= ST_AGE;
                            r_ptr     <= '0;
                            r_pending <= 1'b0;
                        end
                    end
                    ST_AGE: begin
                        // Only one tick can be remembered while busy.
                        if (w_tick) begin
                            r_pending <= 1'b1;
                        end
                        if (!w_learn_ok) begin
                            r_ptr <= r_ptr + PTR_ONE;
                            if (r_ptr == LAST_SLOT) begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_INIT;
                        r_ptr   <= '0;
                        r_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_lookup_valid = r_lookup_valid;
    assign o_hit          = r_hit;
    assign o_port_num     = r_port_num;
    assign o_flood        = r_flood;
    assign o_move         = r_move;
    assign o_ready        = r_ready;
    assign o_entries      = r_entries;

endmodule
